sound_feeder: RTL and testbench

Sample-rate pacing stage directly upstream of the PWM sound generator on the MIO CPLD. The CPU writes 8-bit PCM samples into a small FIFO. A programmable rate divider pops one sample per sample period and presents it to the PWM generator as a one-cycle write strobe plus data. This decouples CPU write timing from the audio sample rate and reports FIFO status and refill interrupts back to the CPU.

---
 rtl/sound_pkg.sv | 19 +
 rtl/sound_fifo.sv | 60 ++++++
 rtl/sound_feeder.sv | 134 +++++++++++++
 tb/tb_sound_feeder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Register map and control-bit positions shared by the sound feeder and its FIFO.
package sound_pkg;

    typedef enum logic [1:0] {
        ADDR_SAMPLE = 2'd0,
        ADDR_DIV_LO = 2'd1,
        ADDR_DIV_HI = 2'd2,
        ADDR_CTRL   = 2'd3
    } reg_addr_e;

    localparam int unsigned CTRL_ENABLE    = 0;
    localparam int unsigned CTRL_IRQ_EN    = 1;
    localparam int unsigned CTRL_FLUSH     = 2;
    localparam int unsigned CTRL_CLR_UNDER = 3;
    localparam int unsigned CTRL_CLR_OVER  = 4;

    localparam int unsigned DIV_W = 16;

endpackage

// File: rtl/sound_fifo.sv
// Single-clock sample FIFO with push, pop and flush; a pop frees a slot for a same-cycle push.
module sound_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [7:0]       head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        pop_ok  = pop && !empty && !flush;
        push_ok = push && (!full || pop_ok) && !flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sound_feeder.sv
// Paces CPU-written PCM samples into the PWM generator at a programmable rate.
// SOUND_FEEDER_UNDERRUN_SILENCE_EN: an underrun tick strobes a zero sample instead of holding.
module sound_feeder
    import sound_pkg::*;
#(
    parameter int unsigned      DEPTH     = 16,
    parameter int unsigned      LVL_W     = 5,
    parameter logic [DIV_W-1:0] RESET_DIV = 16'd624
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       cpu_data,
    input  logic [1:0]       cpu_addr,
    input  logic             cpu_wr,
    output logic [7:0]       snd_data,
    output logic             snd_wr,
    output logic [LVL_W-1:0] fifo_level,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             underrun,
    output logic             overflow,
    output logic             irq
);

    reg_addr_e        addr_sel;
    logic             enable;
    logic             irq_en;
    logic [DIV_W-1:0] divisor;
    logic [DIV_W-1:0] count;
    logic [7:0]       head;

    logic wr_sample;
    logic ctrl_wr;
    logic flush;
    logic clr_under;
    logic clr_over;
    logic disabling;
    logic tick;
    logic pop;
    logic starve;
    logic dropped;

    assign addr_sel = reg_addr_e'(cpu_addr);

    always_comb begin
        wr_sample = cpu_wr && (addr_sel == ADDR_SAMPLE);
        ctrl_wr   = cpu_wr && (addr_sel == ADDR_CTRL);
        flush     = ctrl_wr && cpu_data[CTRL_FLUSH];
        clr_under = ctrl_wr && cpu_data[CTRL_CLR_UNDER];
        clr_over  = ctrl_wr && cpu_data[CTRL_CLR_OVER];
        disabling = ctrl_wr && !cpu_data[CTRL_ENABLE];
        tick      = enable && (count == '0);
        // Flush outranks a coincident tick: nothing is popped and no underrun is logged.
        pop       = tick && !fifo_empty && !flush;
        starve    = tick && fifo_empty && !flush;
        dropped   = wr_sample && fifo_full && !pop;
    end

    sound_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_sample),
        .push_data (cpu_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable  <= 1'b0;
            irq_en  <= 1'b0;
            divisor <= RESET_DIV;
        end else if (cpu_wr) begin
            case (addr_sel)
                ADDR_DIV_LO: divisor[7:0]  <= cpu_data;
                ADDR_DIV_HI: divisor[15:8] <= cpu_data;
                ADDR_CTRL: begin
                    enable <= cpu_data[CTRL_ENABLE];
                    irq_en <= cpu_data[CTRL_IRQ_EN];
                end
                default: ;
            endcase
        end
    end

    // Divisor changes are picked up only at reload; disabling reloads at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RESET_DIV;
        end else if (!enable || disabling || count == '0) begin
            count <= divisor;
        end else begin
            count <= count - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (starve)         underrun <= 1'b1;
            else if (clr_under) underrun <= 1'b0;
            if (dropped)        overflow <= 1'b1;
            else if (clr_over)  overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snd_data <= '0;
            snd_wr   <= 1'b0;
        end else begin
`ifdef SOUND_FEEDER_UNDERRUN_SILENCE_EN
            snd_wr <= pop || starve;
            if (pop)         snd_data <= head;
            else if (starve) snd_data <= '0;
`else
            snd_wr <= pop;
            if (pop) snd_data <= head;
`endif
        end
    end

    assign irq = enable && irq_en && (fifo_level <= LVL_W'(DEPTH / 2));

endmodule

// File: tb/tb_sound_feeder.sv
// Directed and randomized bench for sound_feeder against a queue-based sample-rate model.
module tb_sound_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LVL_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [7:0]       cpu_data = '0;
    logic [1:0]       cpu_addr = '0;
    logic             cpu_wr = 1'b0;
    logic [7:0]       snd_data;
    logic             snd_wr;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             underrun;
    logic             overflow;
    logic             irq;

    always #5 clk = ~clk;

    sound_feeder #(
        .DEPTH     (DEPTH),
        .LVL_W     (LVL_W),
        .RESET_DIV (16'd624)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_data   (cpu_data),
        .cpu_addr   (cpu_addr),
        .cpu_wr     (cpu_wr),
        .snd_data   (snd_data),
        .snd_wr     (snd_wr),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .underrun   (underrun),
        .overflow   (overflow),
        .irq        (irq)
    );

    int n_tests = 0;
    int n_fail = 0;
    int pulses = 0;

    // Reference model: sample queue, countdown to the next tick, sticky flags.
    byte unsigned q[$];
    bit           m_en, m_irq_en, m_under, m_over, m_wr;
    logic [15:0]  m_div;
    int unsigned  m_cnt;
    logic [7:0]   m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 0; m_irq_en = 0; m_under = 0; m_over = 0; m_wr = 0;
        m_div = 16'd624; m_cnt = 624; m_data = 8'h00;
    endtask

    task automatic model_edge(input bit w, input logic [1:0] a, input logic [7:0] d);
        bit tick, ctrl, flush, pop, starve, new_en;
        ctrl   = w && a == 2'd3;
        tick   = m_en && m_cnt == 0;
        flush  = ctrl && d[2];
        pop    = tick && q.size() != 0 && !flush;
        starve = tick && q.size() == 0 && !flush;
        m_wr = pop;
        if (pop) m_data = q.pop_front();
`ifdef SOUND_FEEDER_UNDERRUN_SILENCE_EN
        if (starve) begin m_wr = 1; m_data = 8'h00; end
`endif
        if (w && a == 2'd0) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_over = 1;
        end
        if (starve) m_under = 1;
        else if (ctrl && d[3]) m_under = 0;
        if (ctrl && d[4]) m_over = 0;
        if (flush) q.delete();
        new_en = ctrl ? d[0] : m_en;
        m_cnt = (!m_en || !new_en || m_cnt == 0) ? int'(m_div) : m_cnt - 1;
        m_en = new_en;
        if (ctrl) m_irq_en = d[1];
        if (w && a == 2'd1) m_div[7:0] = d;
        if (w && a == 2'd2) m_div[15:8] = d;
    endtask

    task automatic check_all();
        chk("snd_wr", snd_wr, m_wr);
        chk("snd_data", snd_data, m_data);
        chk("fifo_level", fifo_level, q.size());
        chk("fifo_full", fifo_full, q.size() == DEPTH);
        chk("fifo_empty", fifo_empty, q.size() == 0);
        chk("underrun", underrun, m_under);
        chk("overflow", overflow, m_over);
        chk("irq", irq, m_en && m_irq_en && q.size() <= DEPTH / 2);
    endtask

    task automatic step(input bit w, input logic [1:0] a, input logic [7:0] d);
        cpu_wr = w; cpu_addr = a; cpu_data = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        check_all();
        if (snd_wr) pulses++;
        cpu_wr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d); step(1, 2'd0, d); endtask
    task automatic wreg(input logic [1:0] a, input logic [7:0] d); step(1, a, d); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 2'd0, 8'h00); endtask

    initial begin
        logic [7:0] d;
        model_reset();
        #12;
        check_all();
        reset_n = 1'b1;

        // Three samples at divisor 3: one strobe every 4 clocks, then underrun.
        push(8'h10); push(8'h20); push(8'h30);
        wreg(2'd1, 8'd3); wreg(2'd2, 8'd0); wreg(2'd3, 8'h01);
        pulses = 0;
        idle(14);
        chk("pulses_div3", pulses, 3);
        idle(6);
        chk("underrun_div3", underrun, 1'b1);
`ifdef SOUND_FEEDER_UNDERRUN_SILENCE_EN
        chk("silence_data", snd_data, 8'h00);
`else
        chk("hold_data", snd_data, 8'h30);
`endif

        // Overfill while disabled, then drain at divisor 0 with a push on a full-FIFO tick.
        wreg(2'd3, 8'h1C);
        for (int i = 0; i < 17; i++) push(8'($urandom));
        chk("full_after17", fifo_full, 1'b1);
        chk("level_after17", fifo_level, 16);
        chk("overflow_after17", overflow, 1'b1);
        wreg(2'd3, 8'h10);
        wreg(2'd1, 8'd0);
        wreg(2'd3, 8'h01);
        pulses = 0;
        push(8'hEE);
        chk("level_push_on_tick", fifo_level, 16);
        chk("no_overflow_push_on_tick", overflow, 1'b0);
        idle(16);
        chk("pulses_div0", pulses, 17);
        chk("drained", fifo_level, 0);
        idle(3);

        // Interrupt at half level, then a flush landing on a tick cycle.
        wreg(2'd3, 8'h1E);
        for (int i = 0; i < 9; i++) push(8'($urandom));
        wreg(2'd1, 8'd1);
        wreg(2'd3, 8'h03);
        chk("irq_low_9", irq, 1'b0);
        idle(2);
        chk("irq_at_8", irq, 1'b1);
        idle(1);
        wreg(2'd3, 8'h07);
        chk("flush_no_wr", snd_wr, 1'b0);
        chk("flush_level", fifo_level, 0);
        chk("flush_no_underrun", underrun, 1'b0);
        idle(6);

        // Random register traffic.
        wreg(2'd3, 8'h1C);
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: push(8'($urandom));
                5: wreg(2'd1, 8'($urandom_range(0, 6)));
                6: wreg(2'd2, 8'h00);
                7: begin
                    d = 8'($urandom_range(0, 31));
                    if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
                    wreg(2'd3, d);
                end
                default: idle(1);
            endcase
        end

        // Asynchronous reset mid-stream with five samples queued and a strobe in flight.
        wreg(2'd3, 8'h1C);
        wreg(2'd2, 8'd0);
        wreg(2'd1, 8'd2);
        for (int i = 0; i < 6; i++) push(8'($urandom_range(1, 255)));
        wreg(2'd3, 8'h01);
        idle(3);
        chk("pre_reset_level", fifo_level, 5);
        chk("pre_reset_wr", snd_wr, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        pulses = 0;
        idle(30);
        chk("post_reset_no_wr", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
